instr_fetch_unit: RTL and testbench

Front-end fetch block that supplies the 32-bit instruction stream to the cpu core's instruction input. It issues word reads to instruction memory over a request/grant + in-order response interface, and buffers returned words in a small FIFO. It presents the instructions to the core with a valid/ready handshake and handles taken-branch (BEQ) redirects by flushing queued and in-flight fetches.

---
 rtl/instr_fetch_unit.sv | 158 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: credit-limited word fetch, in-order response FIFO, redirect flush.
// Optional opcode predecode into instr_illegal when PREDECODE_EN is defined.
module instr_fetch_unit #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned PC_STEP  = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic [31:0] instruction,
   output logic [31:0] instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        instr_illegal
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [31:0]   fetch_pc, resp_pc;
   logic [CW-1:0] outstanding, stale, count;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [31:0]   data_mem [DEPTH];
   logic [31:0]   pc_mem   [DEPTH];
   logic          valid_q;
   logic [31:0]   instr_q, pc_q;

   logic          xfer, rsp, drop, push, pop, head_sel;
   logic [CW:0]   used;
   logic [31:0]   fetch_n, resp_n, redirect_word, head_data, head_pc;
   logic [CW-1:0] out_n, stale_n, count_n;
   logic [AW-1:0] wr_n, rd_n;
   logic          unused_low_bits;

   assign redirect_word   = {redirect_pc[31:2], 2'b00};
   assign unused_low_bits = ^redirect_pc[1:0];

   // Credit covers both in-flight requests and buffered entries
   assign used    = {1'b0, outstanding} + {1'b0, count};
   assign mem_req = !rst && (used < (CW+1)'(DEPTH));

   assign xfer = mem_req && mem_gnt;
   assign rsp  = mem_rvalid;
   assign drop = rsp && (stale != '0);
   assign push = rsp && (stale == '0) && !redirect;
   assign pop  = valid_q && instr_ready;

   always_comb begin
      out_n   = outstanding + CW'(xfer) - CW'(rsp);
      fetch_n = fetch_pc;
      resp_n  = resp_pc;
      stale_n = stale;
      count_n = count;
      wr_n    = wr_ptr;
      rd_n    = rd_ptr;
      if (redirect) begin
         // Everything still in flight after this edge belongs to the old stream
         fetch_n = redirect_word;
         resp_n  = redirect_word;
         stale_n = out_n;
         count_n = '0;
         wr_n    = '0;
         rd_n    = '0;
      end else begin
         if (xfer) fetch_n = fetch_pc + 32'(PC_STEP);
         if (drop) stale_n = stale - CW'(1);
         if (push) begin
            resp_n = resp_pc + 32'(PC_STEP);
            wr_n   = wr_ptr + AW'(1);
         end
         if (pop) rd_n = rd_ptr + AW'(1);
         count_n = count + CW'(push) - CW'(pop);
      end
   end

   // Next head comes from the word being written when it lands at the new read slot
   assign head_sel  = push && (wr_ptr == rd_n);
   assign head_data = head_sel ? mem_rdata : data_mem[rd_n];
   assign head_pc   = head_sel ? resp_pc   : pc_mem[rd_n];

`ifdef PREDECODE_EN
   logic ill_mem [DEPTH];
   logic ill_push, head_ill, ill_q;

   always_comb begin
      ill_push = 1'b1;
      case (mem_rdata[31:28])
         4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
         4'h8, 4'hB, 4'hC, 4'hD: ill_push = 1'b0;
         default:               ill_push = 1'b1;
      endcase
   end

   assign head_ill = head_sel ? ill_push : ill_mem[rd_n];

   always_ff @(posedge clk) begin
      if (push) ill_mem[wr_ptr] <= ill_push;
   end

   always_ff @(posedge clk) begin
      if (rst)                 ill_q <= 1'b0;
      else if (count_n != '0)  ill_q <= head_ill;
      else                     ill_q <= 1'b0;
   end

   assign instr_illegal = ill_q;
`else
   assign instr_illegal = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (push) begin
         data_mem[wr_ptr] <= mem_rdata;
         pc_mem[wr_ptr]   <= resp_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         outstanding <= '0;
         stale       <= '0;
         count       <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         valid_q     <= 1'b0;
         instr_q     <= '0;
         pc_q        <= '0;
      end else begin
         fetch_pc    <= fetch_n;
         resp_pc     <= resp_n;
         outstanding <= out_n;
         stale       <= stale_n;
         count       <= count_n;
         wr_ptr      <= wr_n;
         rd_ptr      <= rd_n;
         valid_q     <= (count_n != '0);
         if (count_n != '0) begin
            instr_q <= head_data;
            pc_q    <= head_pc;
         end
      end
   end

   assign mem_addr    = fetch_pc;
   assign instruction = instr_q;
   assign instr_pc    = pc_q;
   assign instr_valid = valid_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit with an in-order, variable-latency memory model.
module tb_instr_fetch_unit;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
      logic        ill;
   } exp_t;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

`ifdef PREDECODE_EN
   localparam bit PD = 1'b1;
`else
   localparam bit PD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_gnt;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata  = 32'h0;
   logic [31:0] instruction;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        instr_illegal;

   logic        gnt_en;
   int          lat;
   int          cyc    = 0;
   int          n_xfer = 0;
   int          total  = 0;
   int          bad    = 0;
   int          base;
   exp_t        exp_q [$];
   pend_t       pend  [$];

   assign mem_gnt = gnt_en;

   instr_fetch_unit dut (
      .clk           (clk),
      .rst           (rst),
      .mem_req       (mem_req),
      .mem_addr      (mem_addr),
      .mem_gnt       (mem_gnt),
      .mem_rvalid    (mem_rvalid),
      .mem_rdata     (mem_rdata),
      .instruction   (instruction),
      .instr_pc      (instr_pc),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .redirect      (redirect),
      .redirect_pc   (redirect_pc),
      .instr_illegal (instr_illegal)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word(input logic [31:0] a);
      case (a)
         32'h0:   return 32'hC123_0001;
         32'h4:   return 32'hC220_0002;
         32'h8:   return 32'h4321_0000;
         32'h100: return 32'h7000_0000;
         32'h104: return 32'hBF00_0003;
         default: return 32'h2A00_0000 ^ a;
      endcase
   endfunction

   function automatic logic exp_ill(input logic [31:0] d);
      return PD && (d[31:28] inside {4'h7, 4'h9, 4'hA, 4'hE, 4'hF});
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   task automatic expect_pc(input logic [31:0] pc);
      exp_t e;
      e.pc   = pc;
      e.data = word(pc);
      e.ill  = exp_ill(e.data);
      exp_q.push_back(e);
   endtask

   task automatic step;
      @(posedge clk);
      #2;
   endtask

   task automatic drain(input int n);
      int i;
      i = 0;
      while (exp_q.size() != 0 && i < n) begin
         @(posedge clk);
         i++;
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   // Memory: grants recorded at the edge, responses returned in order once due
   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         pend.delete();
      end else begin
         if (mem_rvalid && pend.size() != 0) void'(pend.pop_front());
         if (mem_req && mem_gnt) begin
            pend.push_back('{addr: mem_addr, due: cyc + lat});
            n_xfer++;
         end
      end
      #1;
      if (pend.size() != 0 && pend[0].due <= cyc + 1) begin
         mem_rvalid = 1'b1;
         mem_rdata  = word(pend[0].addr);
      end else begin
         mem_rvalid = 1'b0;
      end
   end

   // Monitor: every handshake must match the next expected instruction
   always @(negedge clk) begin
      exp_t e;
      if (!rst && instr_valid && instr_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pop: got pc %h expected none", instr_pc);
         end else begin
            e = exp_q.pop_front();
            chk("pop_pc", instr_pc, e.pc);
            chk("pop_data", instruction, e.data);
            chk("pop_ill", 32'(instr_illegal), 32'(e.ill));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; gnt_en = 1'b0; instr_ready = 1'b0;
      redirect = 1'b0; redirect_pc = 32'h0; lat = 1;
      step; step;
      @(negedge clk);
      chk("rst_req", 32'(mem_req), 32'h0);
      chk("rst_addr", mem_addr, 32'h0);
      chk("rst_valid", 32'(instr_valid), 32'h0);
      chk("rst_instr", instruction, 32'h0);
      chk("rst_pc", instr_pc, 32'h0);
      chk("rst_ill", 32'(instr_illegal), 32'h0);

      // Streaming fetch with 1-cycle memory
      step;
      rst = 1'b0; gnt_en = 1'b1; instr_ready = 1'b1; lat = 1;
      expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8);
      @(negedge clk);
      chk("first_req", 32'(mem_req), 32'h1);
      chk("addr0", mem_addr, 32'h0);
      step; @(negedge clk);
      chk("addr4", mem_addr, 32'h4);
      step; @(negedge clk);
      chk("addr8", mem_addr, 32'h8);
      chk("lat_valid", 32'(instr_valid), 32'h1);
      chk("lat_pc", instr_pc, 32'h0);
      step; gnt_en = 1'b0;
      drain(20);

      // Credit limit with a stalled core
      step;
      instr_ready = 1'b0; gnt_en = 1'b1; base = n_xfer;
      expect_pc(32'hC); expect_pc(32'h10); expect_pc(32'h14); expect_pc(32'h18);
      repeat (10) step;
      @(negedge clk);
      chk("credit_xfers", 32'(n_xfer - base), 32'd4);
      chk("credit_req", 32'(mem_req), 32'h0);
      step; instr_ready = 1'b1;
      expect_pc(32'h1C);
      step; instr_ready = 1'b0;
      repeat (8) step;
      @(negedge clk);
      chk("credit_one_more", 32'(n_xfer - base), 32'd5);
      chk("credit_req2", 32'(mem_req), 32'h0);
      step; gnt_en = 1'b0; instr_ready = 1'b1;
      drain(20);

      // Redirect with three slow fetches in flight
      step; gnt_en = 1'b1; lat = 5;
      step; step;
      step; gnt_en = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0043;
      step; redirect = 1'b0; gnt_en = 1'b1;
      expect_pc(32'h40);
      @(negedge clk);
      chk("redir_addr", mem_addr, 32'h40);
      chk("redir_req", 32'(mem_req), 32'h1);
      step; gnt_en = 1'b0;
      drain(30);

      // Redirect coinciding with a response and a grant
      step; gnt_en = 1'b1; lat = 2;
      step;
      step; redirect = 1'b1; redirect_pc = 32'h0000_0080;
      @(negedge clk);
      chk("coinc_rvalid", 32'(mem_rvalid), 32'h1);
      step; redirect = 1'b0;
      expect_pc(32'h80);
      @(negedge clk);
      chk("coinc_addr", mem_addr, 32'h80);
      step; gnt_en = 1'b0;
      drain(30);

      // Reset while the FIFO holds two entries
      step; instr_ready = 1'b0; gnt_en = 1'b1; lat = 1;
      step;
      step; gnt_en = 1'b0;
      step; step;
      @(negedge clk);
      chk("hold_valid", 32'(instr_valid), 32'h1);
      chk("hold_pc", instr_pc, 32'h84);
      chk("hold_instr", instruction, word(32'h84));
      step; rst = 1'b1;
      @(negedge clk);
      chk("midrst_req", 32'(mem_req), 32'h0);
      step; rst = 1'b0; gnt_en = 1'b1; instr_ready = 1'b1;
      expect_pc(32'h0);
      @(negedge clk);
      chk("post_rst_valid", 32'(instr_valid), 32'h0);
      chk("post_rst_instr", instruction, 32'h0);
      chk("post_rst_req", 32'(mem_req), 32'h1);
      chk("post_rst_addr", mem_addr, 32'h0);
      step; gnt_en = 1'b0;
      drain(20);

      // Predecode: illegal then legal opcode
      step; redirect = 1'b1; redirect_pc = 32'h0000_0100;
      step; redirect = 1'b0; gnt_en = 1'b1;
      expect_pc(32'h100); expect_pc(32'h104);
      step;
      step; gnt_en = 1'b0;
      drain(20);

      step;
      chk("leftover", 32'(exp_q.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
